// File: rtl/proc_pkg.sv
// Shared constants and types for the 8-bit multicycle processor front end.
package proc_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  localparam int unsigned OPC_W  = 4;
  localparam int unsigned IMM3_W = 3;
  localparam int unsigned IMM5_W = 5;
  localparam int unsigned IMM4_W = 4;

  localparam int unsigned OPC_LSB  = 0;
  localparam int unsigned IMM3_LSB = 3;
  localparam int unsigned IMM5_LSB = 3;
  localparam int unsigned IMM4_LSB = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ir_field_split.sv
// Combinational slicing of an instruction word into opcode and immediate fields.
module ir_field_split
  import proc_pkg::*;
(
  input  logic [DATA_W-1:0] ir,
  output logic [OPC_W-1:0]  opcode,
  output logic [IMM3_W-1:0] imm3,
  output logic [IMM5_W-1:0] imm5,
  output logic [IMM4_W-1:0] imm4
);

  assign opcode = ir[OPC_LSB  +: OPC_W];
  assign imm3   = ir[IMM3_LSB +: IMM3_W];
  assign imm5   = ir[IMM5_LSB +: IMM5_W];
  assign imm4   = ir[IMM4_LSB +: IMM4_W];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, req/ack instruction-memory read, and the instruction register
// handed to decode with a valid/ready handshake.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = proc_pkg::ADDR_W,
  parameter int unsigned       DATA_W   = proc_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              fetch_en,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_target,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [DATA_W-1:0] ir,
  output logic [3:0]        opcode,
  output logic [2:0]        imm3,
  output logic [4:0]        imm5,
  output logic [3:0]        imm4,
  output logic [ADDR_W-1:0] pc
);

  proc_pkg::fetch_state_e state_q, state_d;
  logic [ADDR_W-1:0]      pc_q, pc_d;
  logic [DATA_W-1:0]      ir_q, ir_d;
  logic                   ir_valid_q, ir_valid_d;
  logic                   mem_req_q, mem_req_d;

  // Next-state logic; a redirect overrides any fetch progress in the same cycle.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;

    if (pc_load) begin
      pc_d       = pc_target;
      ir_valid_d = 1'b0;
      if (state_q == proc_pkg::S_IDLE) begin
        state_d = proc_pkg::S_IDLE;
      end else begin
        state_d = fetch_en ? proc_pkg::S_REQ : proc_pkg::S_IDLE;
      end
    end else begin
      case (state_q)
        proc_pkg::S_IDLE: begin
          if (fetch_en) state_d = proc_pkg::S_REQ;
        end
        proc_pkg::S_REQ: begin
          if (mem_ack) begin
            ir_d       = mem_rdata;
            pc_d       = pc_q + ADDR_W'(1);
            ir_valid_d = 1'b1;
            state_d    = proc_pkg::S_HOLD;
          end
        end
        proc_pkg::S_HOLD: begin
          if (ir_ready) begin
            ir_valid_d = 1'b0;
            state_d    = fetch_en ? proc_pkg::S_REQ : proc_pkg::S_IDLE;
          end
        end
        default: state_d = proc_pkg::S_IDLE;
      endcase
    end

    mem_req_d = (state_d == proc_pkg::S_REQ);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= proc_pkg::S_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      mem_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      mem_req_q  <= mem_req_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = pc_q;
  assign ir_valid = ir_valid_q;
  assign ir       = ir_q;
  assign pc       = pc_q;

  ir_field_split u_ir_field_split (
    .ir     (ir_q),
    .opcode (opcode),
    .imm3   (imm3),
    .imm5   (imm5),
    .imm4   (imm4)
  );

endmodule
